// File: rtl/reset_seq_unit.sv
// ============================================================================
// reset_seq_unit : PLL-lock qualified core reset sequencer with button debounce
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module reset_seq_unit #(
  parameter logic [15:0] SANITY_CNT   = 16'hAA55,
  parameter logic [15:0] DEBOUNCE_CYC = 16'hFFFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pllLocked,
  input  logic       btnReset,
  output logic       coreReset,
  output logic       runPulse,
  output logic [1:0] resetCause,
  output logic [7:0] resetCount
);

  typedef enum logic [1:0] {
    ST_WAITLOCK = 2'd0,
    ST_COUNT    = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  localparam logic [15:0] c_SANITY_LAST = SANITY_CNT - 16'd1;
  localparam logic [15:0] c_DEB_LAST    = DEBOUNCE_CYC - 16'd1;
  localparam logic [1:0]  c_CAUSE_BTN   = 2'd1;
  localparam logic [1:0]  c_CAUSE_LOCK  = 2'd2;

  logic        r_lock_meta;
  logic        r_lock_s;
  logic        r_btn_meta;
  logic        r_btn_s;
  logic [15:0] r_dcnt;
  logic        r_press_done;
  logic        w_press;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic [1:0]  r_cause;
  logic [1:0]  w_cause_nxt;
  logic        w_exit_run;
  logic [7:0]  r_count;
  logic        r_core_reset;
  logic        r_run_pulse;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_btn_meta  <= 1'b0;
      r_btn_s     <= 1'b0;
    end else begin
      r_lock_meta <= pllLocked;
      r_lock_s    <= r_lock_meta;
      r_btn_meta  <= btnReset;
      r_btn_s     <= r_btn_meta;
    end
  end

  // The press fires on the DEBOUNCE_CYC-th consecutive high cycle of btnS,
  // i.e. while the counter sits at its ceiling and the button is still held.
  assign w_press = r_btn_s && (r_dcnt == c_DEB_LAST) && !r_press_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dcnt       <= 16'd0;
      r_press_done <= 1'b0;
    end else if (!r_btn_s) begin
      r_dcnt       <= 16'd0;
      r_press_done <= 1'b0;
    end else begin
      if (r_dcnt != c_DEB_LAST) begin
        r_dcnt <= r_dcnt + 16'd1;
      end
      if (w_press) begin
        r_press_done <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cause_nxt = r_cause;
    w_exit_run  = 1'b0;
    case (r_state)
      ST_WAITLOCK: begin
        if (r_lock_s) begin
          w_state_nxt = ST_COUNT;
          w_cnt_nxt   = 16'd0;
        end
      end
      ST_COUNT: begin
        if (!r_lock_s) begin
          w_state_nxt = ST_WAITLOCK;
        end else if (w_press) begin
          w_cnt_nxt   = 16'd0;
          w_cause_nxt = c_CAUSE_BTN;
        end else if (r_cnt == c_SANITY_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      ST_RUN: begin
        // Lock loss is tested first so it wins over a coincident press.
        if (!r_lock_s) begin
          w_state_nxt = ST_WAITLOCK;
          w_cause_nxt = c_CAUSE_LOCK;
          w_exit_run  = 1'b1;
        end else if (w_press) begin
          w_state_nxt = ST_WAITLOCK;
          w_cause_nxt = c_CAUSE_BTN;
          w_exit_run  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_WAITLOCK;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_WAITLOCK;
      r_cnt        <= 16'd0;
      r_cause      <= 2'd0;
      r_count      <= 8'd0;
      r_core_reset <= 1'b1;
      r_run_pulse  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cause      <= w_cause_nxt;
      r_core_reset <= (w_state_nxt != ST_RUN);
      r_run_pulse  <= (w_state_nxt == ST_RUN) && (r_state != ST_RUN);
      if (w_exit_run && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign coreReset  = r_core_reset;
  assign runPulse   = r_run_pulse;
  assign resetCause = r_cause;
  assign resetCount = r_count;

endmodule

`default_nettype wire

// File: tb/tb_reset_seq_unit.sv
// ============================================================================
// tb_reset_seq_unit : directed bench with a cycle model of the reset sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_reset_seq_unit;

  localparam int SAN = 16;
  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       pllLocked = 1'b0;
  logic       btnReset = 1'b0;
  logic       coreReset;
  logic       runPulse;
  logic [1:0] resetCause;
  logic [7:0] resetCount;

  int n_checks = 0;
  int n_fail   = 0;

  reset_seq_unit #(
    .SANITY_CNT  (16'(SAN)),
    .DEBOUNCE_CYC(16'(DEB))
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pllLocked (pllLocked),
    .btnReset  (btnReset),
    .coreReset (coreReset),
    .runPulse  (runPulse),
    .resetCause(resetCause),
    .resetCount(resetCount)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phases 0=waiting for lock, 1=qualifying lock, 2=running.
  // Inputs are seen through a two-sample delay line; a press is the
  // DEB-th consecutive cycle the delayed button is high.
  int m_l1, m_l2, m_b1, m_b2, m_lk, m_bt;
  int m_phase, m_prev, m_stable, m_held;
  int m_cause, m_count, m_core, m_pulse;
  bit m_press;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_l1 = 0; m_l2 = 0; m_b1 = 0; m_b2 = 0;
      m_phase = 0; m_stable = 0; m_held = 0;
      m_cause = 0; m_count = 0; m_core = 1; m_pulse = 0;
    end else begin
      m_lk = m_l2; m_bt = m_b2;
      m_l2 = m_l1; m_l1 = int'(pllLocked);
      m_b2 = m_b1; m_b1 = int'(btnReset);
      m_held  = m_bt ? ((m_held < 100000) ? m_held + 1 : m_held) : 0;
      m_press = (m_held == DEB);
      m_prev  = m_phase;
      if (m_phase == 0) begin
        if (m_lk == 1) begin m_phase = 1; m_stable = 0; end
      end else if (m_phase == 1) begin
        if (m_lk == 0) m_phase = 0;
        else if (m_press) begin m_stable = 0; m_cause = 1; end
        else if (m_stable + 1 == SAN) m_phase = 2;
        else m_stable = m_stable + 1;
      end else begin
        if (m_lk == 0 || m_press) begin
          m_phase = 0;
          m_cause = (m_lk == 0) ? 2 : 1;
          m_count = (m_count < 255) ? m_count + 1 : 255;
        end
      end
      m_core  = (m_phase != 2) ? 1 : 0;
      m_pulse = (m_phase == 2 && m_prev != 2) ? 1 : 0;
    end
  end

  always @(posedge clock) begin
    #1;
    if (reset) begin
      chk("model_core",  int'(coreReset),  m_core);
      chk("model_pulse", int'(runPulse),   m_pulse);
      chk("model_cause", int'(resetCause), m_cause);
      chk("model_count", int'(resetCount), m_count);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_run(input string name);
    int k;
    k = 0;
    while (coreReset && k < 200) begin
      tick(1);
      k++;
    end
    chk(name, int'(coreReset), 0);
  endtask

  initial begin
    pllLocked = 1'b1;
    #23;
    chk("rst_core",  int'(coreReset),  1);
    chk("rst_pulse", int'(runPulse),   0);
    chk("rst_cause", int'(resetCause), 0);
    chk("rst_count", int'(resetCount), 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Power-on release at edge SAN+3
    tick(18);
    chk("po_core_e18", int'(coreReset), 1);
    tick(1);
    chk("po_core_e19",  int'(coreReset),  0);
    chk("po_pulse_e19", int'(runPulse),   1);
    chk("po_cause",     int'(resetCause), 0);
    chk("po_count",     int'(resetCount), 0);
    tick(1);
    chk("po_pulse_e20", int'(runPulse), 0);

    // Three-cycle glitch is filtered
    btnReset = 1'b1; tick(3); btnReset = 1'b0;
    tick(10);
    chk("glitch_core",  int'(coreReset),  0);
    chk("glitch_count", int'(resetCount), 0);

    // Ten-cycle press: reset at edge 6, re-run at edge 23
    btnReset = 1'b1;
    tick(5);
    chk("press_core_e5", int'(coreReset), 0);
    tick(1);
    chk("press_core_e6", int'(coreReset),  1);
    chk("press_cause",   int'(resetCause), 1);
    chk("press_count",   int'(resetCount), 1);
    tick(4);
    btnReset = 1'b0;
    tick(12);
    chk("press_core_e22", int'(coreReset), 1);
    tick(1);
    chk("press_core_e23", int'(coreReset),  0);
    chk("press_once",     int'(resetCount), 1);
    tick(3);

    // Lock loss for five cycles, then recovery SAN+3 edges after return
    pllLocked = 1'b0;
    tick(2);
    chk("lock_core_e2", int'(coreReset), 0);
    tick(1);
    chk("lock_core_e3", int'(coreReset),  1);
    chk("lock_cause",   int'(resetCause), 2);
    chk("lock_count",   int'(resetCount), 2);
    tick(2);
    pllLocked = 1'b1;
    tick(18);
    chk("recov_core_e18", int'(coreReset), 1);
    tick(1);
    chk("recov_core_e19", int'(coreReset), 0);
    tick(3);

    // Lock loss and press land on the same edge
    btnReset = 1'b1;
    tick(3);
    pllLocked = 1'b0;
    tick(2);
    chk("simul_core_e5", int'(coreReset), 0);
    tick(1);
    chk("simul_core_e6", int'(coreReset),  1);
    chk("simul_cause",   int'(resetCause), 2);
    chk("simul_count",   int'(resetCount), 3);
    btnReset  = 1'b0;
    pllLocked = 1'b1;
    wait_run("simul_rerun");
    chk("simul_count_after", int'(resetCount), 3);
    tick(2);

    // Asynchronous reset with the qualify counter at 9
    pllLocked = 1'b0; tick(1); pllLocked = 1'b1;
    tick(12);
    chk("mid_count_pre", int'(resetCount), 4);
    #2;
    reset = 1'b0;
    #1;
    chk("async_core",  int'(coreReset),  1);
    chk("async_pulse", int'(runPulse),   0);
    chk("async_cause", int'(resetCause), 0);
    chk("async_count", int'(resetCount), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    tick(18);
    chk("rerst_core_e18", int'(coreReset), 1);
    tick(1);
    chk("rerst_core_e19",  int'(coreReset),  0);
    chk("rerst_pulse_e19", int'(runPulse),   1);
    chk("rerst_count",     int'(resetCount), 0);

    // Saturate the exit counter
    for (int i = 0; i < 260; i++) begin
      pllLocked = 1'b0; tick(1); pllLocked = 1'b1;
      tick(3);
      wait_run("sat_rerun");
    end
    chk("sat_count", int'(resetCount), 255);
    chk("sat_cause", int'(resetCause), 2);

    // Press while qualifying lock restarts the qualify window
    pllLocked = 1'b0; tick(1); pllLocked = 1'b1;
    tick(5);
    btnReset = 1'b1; tick(6); btnReset = 1'b0;
    chk("cnt_press_core", int'(coreReset), 1);
    wait_run("cnt_press_rerun");
    chk("cnt_press_cause", int'(resetCause), 1);
    chk("cnt_press_count", int'(resetCount), 255);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
